multi_cycle_control: RTL and testbench
======================================

# multi_cycle_control

Multi-cycle controller FSM that drives the ALU and datapath of the multi-cycle CPU. It is the initiator side of the `ALUOp`/`zero` interface: it sequences each instruction through IF/ID/EXE/MEM/WB states, issues `ALUOp` and mux/write-enable controls, and consumes the ALU's `zero` flag to resolve branches.

## Interface
- No parameters; opcode map and state encodings are fixed below.
- `CLK`  in  1  — single system clock; all state changes on rising edge.
- `RST`  in  1  — reset, synchronous and active-high.
- `opcode`  in  6  — IR[31:26]; IR is loaded at the end of IF and stable from ID onward.
- `zero`  in  1  — ALU zero flag, combinational in the same cycle.
- `state`  out  3  — current FSM state, for debug.
- `PCWre`  out  1  — PC write enable.
- `IRWre`  out  1  — IR load enable.
- `InsMemRW`  out  1  — instruction memory read.
- `ExtSel`  out  1  — 1 sign-extend imm16, 0 zero-extend.
- `ALUSrcA`  out  1  — 1 selects shamt, 0 selects rs data.
- `ALUSrcB`  out  1  — 1 selects extended imm, 0 selects rt data.
- `ALUOp`  out  3  — 000 add, 001 sub, 010 slt (unsigned), 011 srl, 100 sll, 101 or, 110 and, 111 xor.
- `mRD` / `mWR`  out  1 each  — data memory read / write.
- `DBDataSrc`  out  1  — writeback source: 1 memory, 0 ALU result.
- `WrRegDSrc`  out  1  — 0 PC+4 (jal), 1 DB bus.
- `RegDst`  out  2  — 00 = $31, 01 = rt, 10 = rd.
- `RegWre`  out  1  — register file write enable.
- `PCSrc`  out  2  — 00 PC+4, 01 branch target, 10 jump target, 11 rs.

## Operation
- Opcodes:
  - add 000000, sub 000001, addi 000010
  - or 010000, and 010001, ori 010010, sll 011000
  - slt 100110, sltiu 100111
  - sw 110000, lw 110001, beq 110100
  - j 111000, jr 111001, jal 111010, halt 111111
- Any other opcode is a NOP.
- States: IF 000, ID 001, EXE_LS 010, MEM 011, WB_LD 100, EXE_BR 101, EXE_AL 110, WB_AL 111.
- Transitions:
  - IF→ID always.
  - ID→EXE_AL for ALU ops; ID→EXE_LS for lw/sw; ID→EXE_BR for beq.
  - ID→IF for j/jr/jal/NOP.
  - ID→ID for halt.
  - EXE_AL→WB_AL→IF.
  - EXE_LS→MEM.
  - MEM→WB_LD (lw) or MEM→IF (sw).
  - WB_LD→IF.
  - EXE_BR→IF.
- Outputs are decoded combinationally from the registered state and `opcode`. Every output not listed for a state is 0.
- **IF:** InsMemRW=1, IRWre=1.
- **ID:**
  - j: PCWre=1, PCSrc=10.
  - jr: PCWre=1, PCSrc=11.
  - jal: PCWre=1, PCSrc=10, RegWre=1, RegDst=00, WrRegDSrc=0.
  - NOP: PCWre=1, PCSrc=00.
  - halt: all 0.
- **EXE_AL / WB_AL:**
  - ALUOp per instruction: add/addi 000, sub 001, slt/sltiu 010, sll 100, or/ori 101, and 110.
  - ALUSrcB=1 for addi/ori/sltiu.
  - ALUSrcA=1 for sll.
  - ExtSel=1 except ori.
- **WB_AL additionally:** RegWre=1, WrRegDSrc=1, DBDataSrc=0, PCWre=1, PCSrc=00. RegDst=10 for R-type, 01 for immediate forms.
- **EXE_LS:** ALUOp=000, ALUSrcB=1, ExtSel=1.
- **MEM:** same ALU controls as EXE_LS, plus mRD=1 (lw) or mWR=1 (sw). For sw, MEM also drives PCWre=1, PCSrc=00.
- **WB_LD:** DBDataSrc=1, WrRegDSrc=1, RegDst=01, RegWre=1, PCWre=1, PCSrc=00.
- **EXE_BR:** ALUOp=001, ExtSel=1, PCWre=1. PCSrc=01 if `zero`=1, else 00.

## Timing
- Latency in cycles: ALU ops 4, lw 5, sw 4, beq 3, j/jr/jal/NOP 2.
- PCWre is high in exactly one cycle per instruction: the last one.
- While `RST`=1:
  - Next state is IF.
  - All write enables (PCWre, IRWre, RegWre, mWR, mRD) are forced to 0.
  - After the first clock edge with `RST`=1, `state`=000.
  - The first IF is the first cycle after `RST` falls.
- Reset asserted mid-instruction aborts it. No write enable is active in any cycle where `RST`=1.
- `zero` is sampled only in EXE_BR. A glitch in other states has no effect.
- Halt holds ID indefinitely with PCWre=0. Only `RST` exits it.

## Configuration
- `CTRL_JAL_JR_EN`
  - Defined: jr and jal decode as specified.
  - Undefined: opcodes 111001 and 111010 decode as NOP (2 cycles, PCSrc=00, RegWre=0). j is unaffected.

## Test plan
- RST high 2 cycles, then low → state 000 during reset; cycle after release IRWre=1, InsMemRW=1, PCWre=0.
- add (000000) → states IF,ID,EXE_AL,WB_AL. In WB_AL: RegWre=1, RegDst=10, ALUOp=000, PCWre=1; PCWre=0 in the first three cycles.
- lw then sw → lw takes 5 cycles with mRD=1 in MEM and DBDataSrc=1 in WB_LD. sw takes 4 cycles with mWR=1 only in MEM.
- beq with zero=1, then beq with zero=0 → EXE_BR gives PCSrc=01 then 00, ALUOp=001, PCWre=1 both times.
- jal with macro defined → ID: RegWre=1, RegDst=00, WrRegDSrc=0, PCSrc=10. Without the macro → PCSrc=00, RegWre=0.
- halt, hold 10 cycles, then assert RST in MEM of a following sw → state stays 001 with PCWre=0 during halt; the aborted sw shows mWR=0 during the reset cycle.

Source files
------------

// File: rtl/multi_cycle_control.sv
// Multi-cycle CPU controller: sequences IF/ID/EXE/MEM/WB and decodes datapath controls.
// Optional feature: define CTRL_JAL_JR_EN to decode jr/jal; otherwise they behave as NOP.
module multi_cycle_control (
    input  logic       CLK,
    input  logic       RST,
    input  logic [5:0] opcode,
    input  logic       zero,
    output logic [2:0] state,
    output logic       PCWre,
    output logic       IRWre,
    output logic       InsMemRW,
    output logic       ExtSel,
    output logic       ALUSrcA,
    output logic       ALUSrcB,
    output logic [2:0] ALUOp,
    output logic       mRD,
    output logic       mWR,
    output logic       DBDataSrc,
    output logic       WrRegDSrc,
    output logic [1:0] RegDst,
    output logic       RegWre,
    output logic [1:0] PCSrc
);

    typedef enum logic [2:0] {
        StIf    = 3'b000,
        StId    = 3'b001,
        StExeLs = 3'b010,
        StMem   = 3'b011,
        StWbLd  = 3'b100,
        StExeBr = 3'b101,
        StExeAl = 3'b110,
        StWbAl  = 3'b111
    } state_e;

    localparam logic [5:0] OpAdd   = 6'b000000;
    localparam logic [5:0] OpSub   = 6'b000001;
    localparam logic [5:0] OpAddi  = 6'b000010;
    localparam logic [5:0] OpOr    = 6'b010000;
    localparam logic [5:0] OpAnd   = 6'b010001;
    localparam logic [5:0] OpOri   = 6'b010010;
    localparam logic [5:0] OpSll   = 6'b011000;
    localparam logic [5:0] OpSlt   = 6'b100110;
    localparam logic [5:0] OpSltiu = 6'b100111;
    localparam logic [5:0] OpSw    = 6'b110000;
    localparam logic [5:0] OpLw    = 6'b110001;
    localparam logic [5:0] OpBeq   = 6'b110100;
    localparam logic [5:0] OpJ     = 6'b111000;
    localparam logic [5:0] OpJr    = 6'b111001;
    localparam logic [5:0] OpJal   = 6'b111010;
    localparam logic [5:0] OpHalt  = 6'b111111;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluSlt = 3'b010;
    localparam logic [2:0] AluSll = 3'b100;
    localparam logic [2:0] AluOr  = 3'b101;
    localparam logic [2:0] AluAnd = 3'b110;

    localparam logic [1:0] PcNext   = 2'b00;
    localparam logic [1:0] PcBranch = 2'b01;
    localparam logic [1:0] PcJump   = 2'b10;
    localparam logic [1:0] PcReg    = 2'b11;

    state_e state_q, state_d;

    logic is_r_alu, is_i_alu, is_alu;
    logic is_lw, is_sw, is_beq;
    logic is_j, is_jr, is_jal, is_halt, is_nop;

    logic [2:0] alu_op_dec;
    logic       alu_src_a_dec, alu_src_b_dec, ext_sel_dec;

    // Opcode class decode; IR is stable from ID onward so opcode is used directly.
    always_comb begin
        is_r_alu = (opcode == OpAdd) || (opcode == OpSub) || (opcode == OpOr) ||
                   (opcode == OpAnd) || (opcode == OpSll) || (opcode == OpSlt);
        is_i_alu = (opcode == OpAddi) || (opcode == OpOri) || (opcode == OpSltiu);
        is_alu   = is_r_alu || is_i_alu;
        is_lw    = (opcode == OpLw);
        is_sw    = (opcode == OpSw);
        is_beq   = (opcode == OpBeq);
        is_j     = (opcode == OpJ);
        is_halt  = (opcode == OpHalt);
`ifdef CTRL_JAL_JR_EN
        is_jr    = (opcode == OpJr);
        is_jal   = (opcode == OpJal);
`else
        is_jr    = 1'b0;
        is_jal   = 1'b0;
`endif
        is_nop   = !(is_alu || is_lw || is_sw || is_beq || is_j || is_jr || is_jal ||
                     is_halt);
    end

    always_comb begin
        alu_op_dec    = AluAdd;
        alu_src_a_dec = 1'b0;
        alu_src_b_dec = 1'b0;
        ext_sel_dec   = 1'b1;
        case (opcode)
            OpAdd:   alu_op_dec = AluAdd;
            OpSub:   alu_op_dec = AluSub;
            OpAddi: begin
                alu_op_dec    = AluAdd;
                alu_src_b_dec = 1'b1;
            end
            OpOr:    alu_op_dec = AluOr;
            OpAnd:   alu_op_dec = AluAnd;
            OpOri: begin
                alu_op_dec    = AluOr;
                alu_src_b_dec = 1'b1;
                ext_sel_dec   = 1'b0;
            end
            OpSll: begin
                alu_op_dec    = AluSll;
                alu_src_a_dec = 1'b1;
            end
            OpSlt:   alu_op_dec = AluSlt;
            OpSltiu: begin
                alu_op_dec    = AluSlt;
                alu_src_b_dec = 1'b1;
            end
            default: alu_op_dec = AluAdd;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIf:    state_d = StId;
            StId: begin
                if (is_alu) begin
                    state_d = StExeAl;
                end else if (is_lw || is_sw) begin
                    state_d = StExeLs;
                end else if (is_beq) begin
                    state_d = StExeBr;
                end else if (is_halt) begin
                    state_d = StId;
                end else begin
                    state_d = StIf;
                end
            end
            StExeAl: state_d = StWbAl;
            StWbAl:  state_d = StIf;
            StExeLs: state_d = StMem;
            StMem:   state_d = is_lw ? StWbLd : StIf;
            StWbLd:  state_d = StIf;
            StExeBr: state_d = StIf;
            default: state_d = StIf;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIf;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

    always_comb begin
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        InsMemRW  = 1'b0;
        ExtSel    = 1'b0;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 1'b0;
        ALUOp     = AluAdd;
        mRD       = 1'b0;
        mWR       = 1'b0;
        DBDataSrc = 1'b0;
        WrRegDSrc = 1'b0;
        RegDst    = 2'b00;
        RegWre    = 1'b0;
        PCSrc     = PcNext;
        case (state_q)
            StIf: begin
                InsMemRW = 1'b1;
                IRWre    = 1'b1;
            end
            StId: begin
                if (is_j) begin
                    PCWre = 1'b1;
                    PCSrc = PcJump;
                end else if (is_jr) begin
                    PCWre = 1'b1;
                    PCSrc = PcReg;
                end else if (is_jal) begin
                    PCWre     = 1'b1;
                    PCSrc     = PcJump;
                    RegWre    = 1'b1;
                    RegDst    = 2'b00;
                    WrRegDSrc = 1'b0;
                end else if (is_nop) begin
                    PCWre = 1'b1;
                    PCSrc = PcNext;
                end
            end
            StExeAl, StWbAl: begin
                ALUOp   = alu_op_dec;
                ALUSrcA = alu_src_a_dec;
                ALUSrcB = alu_src_b_dec;
                ExtSel  = ext_sel_dec;
                if (state_q == StWbAl) begin
                    RegWre    = 1'b1;
                    WrRegDSrc = 1'b1;
                    DBDataSrc = 1'b0;
                    PCWre     = 1'b1;
                    PCSrc     = PcNext;
                    RegDst    = is_r_alu ? 2'b10 : 2'b01;
                end
            end
            StExeLs, StMem: begin
                ALUOp   = AluAdd;
                ALUSrcB = 1'b1;
                ExtSel  = 1'b1;
                if (state_q == StMem) begin
                    mRD = is_lw;
                    mWR = is_sw;
                    if (is_sw) begin
                        PCWre = 1'b1;
                        PCSrc = PcNext;
                    end
                end
            end
            StWbLd: begin
                DBDataSrc = 1'b1;
                WrRegDSrc = 1'b1;
                RegDst    = 2'b01;
                RegWre    = 1'b1;
                PCWre     = 1'b1;
                PCSrc     = PcNext;
            end
            StExeBr: begin
                ALUOp  = AluSub;
                ExtSel = 1'b1;
                PCWre  = 1'b1;
                PCSrc  = zero ? PcBranch : PcNext;
            end
            default: PCWre = 1'b0;
        endcase
        // Reset must never let a write through, even before state_q returns to IF.
        if (RST) begin
            PCWre  = 1'b0;
            IRWre  = 1'b0;
            RegWre = 1'b0;
            mWR    = 1'b0;
            mRD    = 1'b0;
        end
    end

endmodule

// File: tb/tb_multi_cycle_control.sv
// Bench for multi_cycle_control: per-instruction cycle timelines checked against a table model.
module tb_multi_cycle_control;

    logic       CLK, RST, zero;
    logic [5:0] opcode;
    logic [2:0] state, ALUOp;
    logic       PCWre, IRWre, InsMemRW, ExtSel, ALUSrcA, ALUSrcB;
    logic       mRD, mWR, DBDataSrc, WrRegDSrc, RegWre;
    logic [1:0] RegDst, PCSrc;

    int n_total = 0;
    int n_bad   = 0;

`ifdef CTRL_JAL_JR_EN
    localparam bit JalJrEn = 1'b1;
`else
    localparam bit JalJrEn = 1'b0;
`endif

    localparam int CAluR = 0, CAluI = 1, CLw = 2, CSw = 3, CBeq = 4;
    localparam int CJ = 5, CJr = 6, CJal = 7, CHalt = 8, CNop = 9;

    localparam logic [5:0] OPS [17] = '{
        6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001, 6'b010010,
        6'b011000, 6'b100110, 6'b100111, 6'b110000, 6'b110001, 6'b110100,
        6'b111000, 6'b111001, 6'b111010, 6'b111111, 6'b001111
    };

    multi_cycle_control dut (
        .CLK       (CLK),
        .RST       (RST),
        .opcode    (opcode),
        .zero      (zero),
        .state     (state),
        .PCWre     (PCWre),
        .IRWre     (IRWre),
        .InsMemRW  (InsMemRW),
        .ExtSel    (ExtSel),
        .ALUSrcA   (ALUSrcA),
        .ALUSrcB   (ALUSrcB),
        .ALUOp     (ALUOp),
        .mRD       (mRD),
        .mWR       (mWR),
        .DBDataSrc (DBDataSrc),
        .WrRegDSrc (WrRegDSrc),
        .RegDst    (RegDst),
        .RegWre    (RegWre),
        .PCSrc     (PCSrc)
    );

    logic [20:0] got;
    assign got = {state, PCWre, IRWre, InsMemRW, ExtSel, ALUSrcA, ALUSrcB, ALUOp,
                  mRD, mWR, DBDataSrc, WrRegDSrc, RegDst, RegWre, PCSrc};

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int classify(input logic [5:0] op);
        case (op)
            6'b000000, 6'b000001, 6'b010000, 6'b010001, 6'b011000, 6'b100110: return CAluR;
            6'b000010, 6'b010010, 6'b100111: return CAluI;
            6'b110001: return CLw;
            6'b110000: return CSw;
            6'b110100: return CBeq;
            6'b111000: return CJ;
            6'b111001: return JalJrEn ? CJr : CNop;
            6'b111010: return JalJrEn ? CJal : CNop;
            6'b111111: return CHalt;
            default:   return CNop;
        endcase
    endfunction

    function automatic int latency(input logic [5:0] op);
        case (classify(op))
            CAluR, CAluI, CSw: return 4;
            CLw:               return 5;
            CBeq:              return 3;
            default:           return 2;
        endcase
    endfunction

    // Expected outputs in cycle k of an instruction (k=0 is its IF cycle).
    function automatic logic [20:0] model(input logic [5:0] op, input int k, input logic z,
                                          input logic rst);
        int cls;
        logic [2:0] st, aop;
        logic pcw, irw, imr, ext, sa, sb, mrd, mwr, dbs, wrs, rw;
        logic [1:0] rd, pcs;
        cls = classify(op);
        st = 3'd0; aop = 3'd0; rd = 2'd0; pcs = 2'd0;
        {pcw, irw, imr, ext, sa, sb, mrd, mwr, dbs, wrs, rw} = '0;
        if (k == 0) begin
            imr = 1'b1; irw = 1'b1;
        end else if (k == 1) begin
            st = 3'b001;
            case (cls)
                CJ:   begin pcw = 1'b1; pcs = 2'b10; end
                CJr:  begin pcw = 1'b1; pcs = 2'b11; end
                CJal: begin pcw = 1'b1; pcs = 2'b10; rw = 1'b1; end
                CNop: pcw = 1'b1;
                default: pcw = 1'b0;
            endcase
        end else begin
            case (cls)
                CAluR, CAluI: begin
                    case (op)
                        6'b000001: aop = 3'b001;
                        6'b010000: aop = 3'b101;
                        6'b010010: aop = 3'b101;
                        6'b010001: aop = 3'b110;
                        6'b011000: aop = 3'b100;
                        6'b100110: aop = 3'b010;
                        6'b100111: aop = 3'b010;
                        default:   aop = 3'b000;
                    endcase
                    sa  = (op == 6'b011000);
                    sb  = (cls == CAluI);
                    ext = (op != 6'b010010);
                    st  = (k == 2) ? 3'b110 : 3'b111;
                    if (k == 3) begin
                        rw = 1'b1; wrs = 1'b1; pcw = 1'b1;
                        rd = (cls == CAluR) ? 2'b10 : 2'b01;
                    end
                end
                CLw, CSw: begin
                    if (k == 4) begin
                        st = 3'b100; dbs = 1'b1; wrs = 1'b1; rd = 2'b01; rw = 1'b1;
                        pcw = 1'b1;
                    end else begin
                        sb = 1'b1; ext = 1'b1;
                        st = (k == 2) ? 3'b010 : 3'b011;
                        if (k == 3) begin
                            mrd = (cls == CLw);
                            mwr = (cls == CSw);
                            pcw = (cls == CSw);
                        end
                    end
                end
                CBeq: begin
                    st = 3'b101; aop = 3'b001; ext = 1'b1; pcw = 1'b1;
                    pcs = z ? 2'b01 : 2'b00;
                end
                default: st = 3'b001;
            endcase
        end
        if (rst) begin
            {pcw, irw, rw, mwr, mrd} = '0;
        end
        return {st, pcw, irw, imr, ext, sa, sb, aop, mrd, mwr, dbs, wrs, rd, rw, pcs};
    endfunction

    // Runs one instruction from its IF cycle; rst_at >= 0 aborts it with RST in that cycle.
    // zmode < 0 drives random zero every cycle, otherwise a fixed value.
    task automatic run_instr(input logic [5:0] op, input int rst_at, input int zmode);
        int len;
        len = (classify(op) == CHalt) ? rst_at + 1 : latency(op);
        for (int k = 0; k < len; k++) begin
            opcode = (k == 0) ? 6'($urandom) : op;
            zero   = (zmode < 0) ? 1'($urandom) : 1'(zmode);
            RST    = (k == rst_at);
            @(negedge CLK);
            check_val($sformatf("op=%b cyc=%0d rst=%0b", op, k, RST), 32'(got),
                      32'(model(op, k, zero, RST)));
            @(posedge CLK);
            #1;
            if (RST) begin
                RST = 1'b0;
                break;
            end
        end
    endtask

    initial begin
        logic [5:0] op;
        int rst_at;
        RST = 1'b1;
        opcode = 6'd0;
        zero = 1'b0;
        @(posedge CLK);
        #1;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            check_val("reset", 32'(got), 32'(model(opcode, 0, zero, 1'b1)));
            @(posedge CLK);
            #1;
        end
        RST = 1'b0;

        run_instr(6'b000000, -1, -1);
        run_instr(6'b110001, -1, -1);
        run_instr(6'b110000, -1, -1);
        run_instr(6'b110100, -1, 1);
        run_instr(6'b110100, -1, 0);
        run_instr(6'b111010, -1, -1);
        run_instr(6'b111001, -1, -1);
        run_instr(6'b111000, -1, -1);
        run_instr(6'b001111, -1, -1);
        for (int i = 1; i < 9; i++) run_instr(OPS[i], -1, -1);
        run_instr(6'b111111, 11, -1);
        run_instr(6'b110000, 3, -1);

        for (int n = 0; n < 250; n++) begin
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : OPS[$urandom_range(0, 16)];
            if (classify(op) == CHalt) begin
                rst_at = int'($urandom_range(1, 12));
            end else if ($urandom_range(0, 7) == 0) begin
                rst_at = int'($urandom_range(0, latency(op) - 1));
            end else begin
                rst_at = -1;
            end
            run_instr(op, rst_at, -1);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
